uart_program_loader: RTL and testbench

Boot-time loader sitting directly upstream of the program memory on the Nexys4 top level. Receives a framed program image over a UART RX pin (8N1) and writes it byte-by-byte into program memory. Holds the core in reset until a complete, checksum-verified image is in place. Each newly received sync byte restarts the sequence and re-asserts the hold.

---
 rtl/uart_program_loader_if.sv | 11 +
 rtl/uart_program_loader.sv | 189 ++++++++++++++++++
 tb/tb_uart_program_loader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_program_loader_if.sv
// Program-memory byte write port driven by the UART program loader.
interface uart_program_loader_if #(
    parameter int unsigned PROGRAM_ADDR_WIDTH = 5
);
    logic [PROGRAM_ADDR_WIDTH-1:0] pm_addr;
    logic [7:0]                    pm_data;
    logic                          pm_we;

    modport master (output pm_addr, output pm_data, output pm_we);
    modport slave  (input  pm_addr, input  pm_data, input  pm_we);
endinterface

// File: rtl/uart_program_loader.sv
// Boot loader: receives a framed program image over 8N1 UART, writes it into
// program memory and holds the core in reset until the image checksum matches.
module uart_program_loader #(
    parameter int unsigned CLKS_PER_BIT       = 868,
    parameter int unsigned PROGRAM_ADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    uart_program_loader_if.master  pm,
    output logic                   core_hold,
    output logic                   load_done,
    output logic                   load_error
);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW           = PROGRAM_ADDR_WIDTH;
    localparam int unsigned PROGRAM_SIZE = 1 << AW;
    localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]      ADDR_ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_SYNC, P_LEN_LO, P_LEN_HI, P_DATA, P_CSUM} p_state_t;

    logic             rx_meta_q, rx_sync_q;
    rx_state_t        rx_state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             byte_valid_q, frame_err_q;

    p_state_t         p_state_q;
    logic [7:0]       len_lo_q;
    logic [15:0]      remain_q;
    logic [AW:0]      addr_q;
    logic [7:0]       csum_q;
    logic             pm_we_q;
    logic [AW-1:0]    pm_addr_q;
    logic [7:0]       pm_data_q;
    logic             core_hold_q, load_done_q, load_error_q;

    logic [15:0]      len_full;
    logic             addr_msb_unused;

    assign len_full        = {shift_q, len_lo_q};
    assign addr_msb_unused = addr_q[AW];

    // Two-flop synchronizer for the asynchronous rx pin (idles high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // 8N1 receiver: mid-bit sampling, one-cycle byte_valid / frame_err pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_sync_q) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q      <= '0;
                        bit_q      <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_BITS;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RX_BITS: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q        <= '0;
                        byte_valid_q <= rx_sync_q;
                        frame_err_q  <= !rx_sync_q;
                        rx_state_q   <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Frame parser: sync / length / payload writes / checksum, drives status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_state_q    <= P_SYNC;
            len_lo_q     <= '0;
            remain_q     <= '0;
            addr_q       <= '0;
            csum_q       <= '0;
            pm_we_q      <= 1'b0;
            pm_addr_q    <= '0;
            pm_data_q    <= '0;
            core_hold_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            pm_we_q <= 1'b0;
            if (frame_err_q) begin
                load_error_q <= 1'b1;
                p_state_q    <= P_SYNC;
            end else if (byte_valid_q) begin
                case (p_state_q)
                    P_SYNC: begin
                        if (shift_q == SYNC_BYTE) begin
                            core_hold_q  <= 1'b1;
                            load_done_q  <= 1'b0;
                            load_error_q <= 1'b0;
                            addr_q       <= '0;
                            csum_q       <= '0;
                            remain_q     <= '0;
                            p_state_q    <= P_LEN_LO;
                        end
                    end
                    P_LEN_LO: begin
                        len_lo_q  <= shift_q;
                        p_state_q <= P_LEN_HI;
                    end
                    P_LEN_HI: begin
                        remain_q <= len_full;
                        if ({1'b0, len_full} > 17'(PROGRAM_SIZE)) begin
                            load_error_q <= 1'b1;
                            p_state_q    <= P_SYNC;
                        end else if (len_full == 16'd0) begin
                            p_state_q <= P_CSUM;
                        end else begin
                            p_state_q <= P_DATA;
                        end
                    end
                    P_DATA: begin
                        pm_we_q   <= 1'b1;
                        pm_addr_q <= addr_q[AW-1:0];
                        pm_data_q <= shift_q;
                        csum_q    <= csum_q ^ shift_q;
                        addr_q    <= addr_q + ADDR_ONE;
                        remain_q  <= remain_q - 16'd1;
                        if (remain_q == 16'd1) p_state_q <= P_CSUM;
                    end
                    P_CSUM: begin
                        if (shift_q == csum_q) begin
                            core_hold_q <= 1'b0;
                            load_done_q <= 1'b1;
                        end else begin
                            load_error_q <= 1'b1;
                        end
                        p_state_q <= P_SYNC;
                    end
                    default: p_state_q <= P_SYNC;
                endcase
            end
        end
    end

    assign pm.pm_we    = pm_we_q;
    assign pm.pm_addr  = pm_addr_q;
    assign pm.pm_data  = pm_data_q;
    assign core_hold   = core_hold_q;
    assign load_done   = load_done_q;
    assign load_error  = load_error_q;
endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: byte-level reference model, per-cycle compare
// of writes and status, directed scenarios plus randomized frames.
module tb_uart_program_loader;
    localparam int unsigned CPB = 16;
    localparam int unsigned AW  = 5;
    localparam int unsigned PSZ = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic core_hold, load_done, load_error;

    uart_program_loader_if #(.PROGRAM_ADDR_WIDTH(AW)) pm_if ();

    uart_program_loader #(.CLKS_PER_BIT(CPB), .PROGRAM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .rx(rx), .pm(pm_if),
        .core_hold(core_hold), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    int         m_ph = 0;
    int         m_len, m_rem, m_addr;
    logic [7:0] m_lenlo, m_cs;
    bit         e_hold = 1, e_done = 0, e_err = 0;
    bit         n_hold = 1, n_done = 0, n_err = 0;
    int         exp_addr[$];
    logic [7:0] exp_data[$];
    bit         in_flight = 0;

    logic [7:0] mem_seen [PSZ];
    int         we_count = 0;
    int         last_start_cyc = 0;
    int         hold_rise_cyc = -1, done_fall_cyc = -1;
    logic       prev_hold = 1'b1, prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // What the loader must do with one received byte (ferr = bad stop bit).
    task automatic model_byte(input logic [7:0] b, input bit ferr);
        if (ferr) begin
            n_err = 1; m_ph = 0;
        end else begin
            case (m_ph)
                0: if (b == 8'hA5) begin
                       n_hold = 1; n_done = 0; n_err = 0;
                       m_addr = 0; m_cs = 8'h00; m_ph = 1;
                   end
                1: begin m_lenlo = b; m_ph = 2; end
                2: begin
                       m_len = int'(b) * 256 + int'(m_lenlo);
                       if (m_len > int'(PSZ)) begin n_err = 1; m_ph = 0; end
                       else if (m_len == 0) m_ph = 4;
                       else begin m_rem = m_len; m_ph = 3; end
                   end
                3: begin
                       exp_addr.push_back(m_addr); exp_data.push_back(b);
                       m_cs = m_cs ^ b; m_addr++; m_rem--;
                       if (m_rem == 0) m_ph = 4;
                   end
                default: begin
                       if (b == m_cs) begin n_hold = 0; n_done = 1; end
                       else n_err = 1;
                       m_ph = 0;
                   end
            endcase
        end
    endtask

    task automatic bit_wait();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Serialise one 8N1 byte; called at posedge+1 phase, returns in the same phase.
    task automatic send_byte(input logic [7:0] b, input bit stop);
        model_byte(b, !stop);
        last_start_cyc = cyc;
        rx = 1'b0; bit_wait();
        for (int i = 0; i < 8; i++) begin rx = b[i]; bit_wait(); end
        in_flight = 1; rx = stop; bit_wait();
        rx = 1'b1;
        e_hold = n_hold; e_done = n_done; e_err = n_err;
        in_flight = 0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string name, input bit h, input bit d, input bit e);
        chk({name, ".core_hold"},  32'(core_hold),  32'(h));
        chk({name, ".load_done"},  32'(load_done),  32'(d));
        chk({name, ".load_error"}, 32'(load_error), 32'(e));
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk_status("reset", 1, 0, 0);
        chk("reset.pm_we",   32'(pm_if.pm_we),   32'd0);
        chk("reset.pm_addr", 32'(pm_if.pm_addr), 32'd0);
        chk("reset.pm_data", 32'(pm_if.pm_data), 32'd0);
        chk("reset.pending_writes", 32'(exp_addr.size()), 32'd0);
        m_ph = 0;
        e_hold = 1; e_done = 0; e_err = 0;
        n_hold = 1; n_done = 0; n_err = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        gap(2);
    endtask

    // Per-cycle compare of write port and status against the model.
    always @(negedge clk) begin
        if (reset) begin
            if (pm_if.pm_we) begin
                if (exp_addr.size() == 0) begin
                    chk("unexpected_pm_we", 32'd1, 32'd0);
                end else begin
                    chk("pm_addr", 32'(pm_if.pm_addr), 32'(exp_addr.pop_front()));
                    chk("pm_data", 32'(pm_if.pm_data), 32'(exp_data.pop_front()));
                end
                mem_seen[pm_if.pm_addr] = pm_if.pm_data;
                we_count++;
            end
            if (!in_flight) begin
                chk("core_hold",  32'(core_hold),  32'(e_hold));
                chk("load_done",  32'(load_done),  32'(e_done));
                chk("load_error", 32'(load_error), 32'(e_err));
            end
            if (core_hold && !prev_hold) hold_rise_cyc = cyc;
            if (!load_done && prev_done) done_fall_cyc = cyc;
        end
        prev_hold = core_hold;
        prev_done = load_done;
    end

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i], 1);
    endtask

    task automatic rand_frame();
        logic [7:0] fr[$];
        logic [7:0] b, cs;
        int nj, len, fpos;
        bit ferr_en;
        nj = $urandom_range(0, 2);
        for (int i = 0; i < nj; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            fr.push_back(b);
        end
        len = ($urandom_range(0, 7) == 0) ? 33 + $urandom_range(0, 300) : $urandom_range(0, 12);
        fr.push_back(8'hA5);
        fr.push_back(8'(len));
        fr.push_back(8'(len >> 8));
        if (len <= int'(PSZ)) begin
            cs = 8'h00;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                cs = cs ^ b;
                fr.push_back(b);
            end
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            fr.push_back(cs);
        end
        ferr_en = ($urandom_range(0, 9) == 0);
        fpos = $urandom_range(0, fr.size() - 1);
        foreach (fr[i]) begin
            gap($urandom_range(0, CPB));
            send_byte(fr[i], !(ferr_en && i == fpos));
        end
        gap(CPB);
    endtask

    int base;
    logic [7:0] big[$];

    initial begin
        #2 reset = 1'b0;
        #1 chk_status("por", 1, 0, 0);
        chk("por.pm_we", 32'(pm_if.pm_we), 32'd0);
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1 reset = 1'b1;
        gap(4);

        // clean load
        base = we_count;
        send_seq('{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00});
        gap(4);
        chk("clean.writes", 32'(we_count - base), 32'd3);
        chk("clean.m0", 32'(mem_seen[0]), 32'h11);
        chk("clean.m1", 32'(mem_seen[1]), 32'h22);
        chk("clean.m2", 32'(mem_seen[2]), 32'h33);
        chk_status("clean", 0, 1, 0);

        // bad checksum
        base = we_count;
        send_seq('{8'hA5, 8'h02, 8'h00, 8'hAA, 8'h55, 8'h00});
        gap(4);
        chk("badcs.writes", 32'(we_count - base), 32'd2);
        chk("badcs.m1", 32'(mem_seen[1]), 32'h55);
        chk_status("badcs", 1, 0, 1);

        // oversize then recovery
        base = we_count;
        send_seq('{8'hA5, 8'h21, 8'h00});
        gap(4);
        chk("oversize.writes", 32'(we_count - base), 32'd0);
        chk_status("oversize", 1, 0, 1);
        send_seq('{8'hA5, 8'h01, 8'h00, 8'h7E, 8'h7E});
        gap(4);
        chk("recover.m0", 32'(mem_seen[0]), 32'h7E);
        chk_status("recover", 0, 1, 0);

        // framing error then an ignored byte
        send_byte(8'hA5, 1);
        send_byte(8'h00, 0);
        gap(4);
        chk_status("ferr", 1, 0, 1);
        base = we_count;
        send_byte(8'h3C, 1);
        gap(4);
        chk_status("ferr.ignored", 1, 0, 1);

        // glitch then zero-length frame
        rx = 1'b0; gap(4); rx = 1'b1; gap(3 * CPB);
        chk_status("glitch", 1, 0, 1);
        send_seq('{8'hA5, 8'h00, 8'h00, 8'h00});
        gap(4);
        chk("zero.writes", 32'(we_count - base), 32'd0);
        chk_status("zero", 0, 1, 0);

        // reset mid-payload, then full reload
        send_seq('{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02});
        apply_reset();
        send_seq('{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04});
        gap(4);
        chk("reload.m3", 32'(mem_seen[3]), 32'h04);
        chk_status("reload", 0, 1, 0);

        // a new sync re-asserts the hold, timed from the start edge
        hold_rise_cyc = -1; done_fall_cyc = -1;
        send_byte(8'hA5, 1);
        gap(4);
        chk("resync.same_cycle", 32'(hold_rise_cyc), 32'(done_fall_cyc));
        chk("resync.latency_ok",
            32'((hold_rise_cyc - last_start_cyc >= int'(9 * CPB + CPB / 2)) &&
                (hold_rise_cyc - last_start_cyc <= int'(10 * CPB))), 32'd1);
        chk_status("resync", 1, 0, 0);
        send_seq('{8'h00, 8'h00, 8'h00});

        // full-size image (LEN = PROGRAM_SIZE)
        big = '{8'hA5, 8'(PSZ), 8'(PSZ >> 8)};
        m_cs = 8'h00;
        for (int i = 0; i < int'(PSZ); i++) big.push_back(8'(i * 7 + 3));
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 0; i < int'(PSZ); i++) x = x ^ 8'(i * 7 + 3);
            big.push_back(x);
        end
        send_seq(big);
        gap(4);
        chk("full.m31", 32'(mem_seen[PSZ-1]), 32'(8'((PSZ - 1) * 7 + 3)));
        chk_status("full", 0, 1, 0);

        // randomized frames
        for (int f = 0; f < 10; f++) rand_frame();

        gap(2 * CPB);
        chk("end.pending_writes", 32'(exp_addr.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1, "watchdog");
    end
endmodule
